freq_meas_sched: RTL and testbench

Measurement scheduler for the frequency-meter path. It sequences the counter datapath: clear, open gate for a fixed reference window, close gate, then wait for the datapath's done report. It latches the reported fx and gate counts and streams them as a 10-byte frame to the UART transmitter over a valid/ready byte handshake. It sits between the counter datapath (clk_fx side, already synchronised into clk) and the UART TX.

---
 rtl/freq_meas_pkg.sv | 43 ++++
 rtl/freq_meas_sched_if.sv | 10 +
 rtl/freq_meas_sched_frame_tx.sv | 102 ++++++++++
 rtl/freq_meas_sched.sv | 162 ++++++++++++++++
 tb/tb_freq_meas_sched.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the frequency-meter measurement scheduler.
// Holds the state encoding, frame constants and the frame byte selector.
package freq_meas_pkg;

    localparam int CNT_W     = 32;
    localparam int FRAME_LEN = 10;

    localparam logic [7:0] HDR_OK = 8'h55;
    localparam logic [7:0] HDR_TO = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_GATE    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_SEND    = 3'd4,
        ST_HOLDOFF = 3'd5
    } state_e;

    // Bytes 0..8 of a frame; byte 9 (checksum) is produced by the accumulator.
    function automatic logic [7:0] frame_byte(
        input logic [3:0]       idx,
        input logic [7:0]       hdr,
        input logic [CNT_W-1:0] fx,
        input logic [CNT_W-1:0] gate
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = hdr;
            4'd1:    b = fx[31:24];
            4'd2:    b = fx[23:16];
            4'd3:    b = fx[15:8];
            4'd4:    b = fx[7:0];
            4'd5:    b = gate[31:24];
            4'd6:    b = gate[23:16];
            4'd7:    b = gate[15:8];
            4'd8:    b = gate[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/freq_meas_sched_if.sv
// Byte stream from the measurement scheduler to the UART transmitter.
// The master presents tx_data/tx_valid; the slave answers with tx_ready.
interface freq_meas_sched_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/freq_meas_sched_frame_tx.sv
// Frame sequencer: latches a measurement on load and streams the 10-byte
// frame over valid/ready, summing bytes 1..8 into the trailing checksum.
module meas_frame_tx
    import freq_meas_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [7:0]       hdr,
    input  logic [CNT_W-1:0] fx,
    input  logic [CNT_W-1:0] gate,
    freq_meas_sched_if.master tx,
    output logic             last_xfer,
    output logic             done
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    logic [7:0]       hdr_q, hdr_d;
    logic [CNT_W-1:0] fx_q, fx_d;
    logic [CNT_W-1:0] gate_q, gate_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       chk_q, chk_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             xfer_s;

    assign xfer_s    = valid_q & tx.tx_ready;
    assign last_xfer = xfer_s & (idx_q == LAST_IDX);

    // Next-state for the byte index, checksum and presented byte.
    always_comb begin
        hdr_d   = hdr_q;
        fx_d    = fx_q;
        gate_d  = gate_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        if (load && !valid_q) begin
            hdr_d   = hdr;
            fx_d    = fx;
            gate_d  = gate;
            idx_d   = 4'd0;
            chk_d   = 8'h00;
            data_d  = hdr;
            valid_d = 1'b1;
        end else if (xfer_s) begin
            if (idx_q == LAST_IDX) begin
                idx_d   = 4'd0;
                data_d  = 8'h00;
                valid_d = 1'b0;
                done_d  = 1'b1;
            end else begin
                idx_d = idx_q + 4'd1;
                // The header never enters the checksum.
                if (idx_q != 4'd0) begin
                    chk_d = chk_q + data_q;
                end else begin
                    chk_d = chk_q;
                end
                if (idx_q == (LAST_IDX - 4'd1)) begin
                    data_d = chk_q + data_q;
                end else begin
                    data_d = frame_byte(idx_q + 4'd1, hdr_q, fx_q, gate_q);
                end
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Frame registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_q   <= 8'h00;
            fx_q    <= {CNT_W{1'b0}};
            gate_q  <= {CNT_W{1'b0}};
            idx_q   <= 4'd0;
            chk_q   <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            hdr_q   <= hdr_d;
            fx_q    <= fx_d;
            gate_q  <= gate_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
    assign done        = done_q;

endmodule

// File: rtl/freq_meas_sched.sv
// Measurement scheduler: clear, gate window, wait for counts (with timeout),
// ship the result frame, hold off, and repeat while en stays high.
module freq_meas_sched
    import freq_meas_pkg::*;
#(
    parameter logic [31:0] GATE_CYCLES    = 32'd20_000_000,
    parameter logic [31:0] HOLDOFF_CYCLES = 32'd1_000_000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             cnt_clr,
    output logic             gate_en,
    input  logic             cnt_done,
    input  logic [CNT_W-1:0] fx_cnt,
    input  logic [CNT_W-1:0] gate_cnt,
    freq_meas_sched_if.master tx,
    output logic             busy,
    output logic             meas_done
);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_CLEAR   = ST_CLEAR;
    localparam logic [2:0] S_GATE    = ST_GATE;
    localparam logic [2:0] S_WAIT    = ST_WAIT;
    localparam logic [2:0] S_SEND    = ST_SEND;
    localparam logic [2:0] S_HOLDOFF = ST_HOLDOFF;

    // Counters run down to zero from N-1 so a state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] GATE_LOAD = (GATE_CYCLES    > 32'd0) ? (GATE_CYCLES    - 32'd1) : 32'd0;
    localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF_CYCLES > 32'd0) ? (HOLDOFF_CYCLES - 32'd1) : 32'd0;
    localparam logic [CNT_W-1:0] TO_LOAD   = (TIMEOUT_CYCLES > 32'd0) ? (TIMEOUT_CYCLES - 32'd1) : 32'd0;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] to_q, to_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             gate_en_q, gate_en_d;
    logic             busy_q, busy_d;

    logic             load_s;
    logic [7:0]       hdr_s;
    logic [CNT_W-1:0] fx_s;
    logic [CNT_W-1:0] gate_s;
    logic             last_xfer_s;
    logic             done_s;

    // FSM next-state, counter reloads and frame load request.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        to_d    = to_q;
        load_s  = 1'b0;
        hdr_s   = HDR_OK;
        fx_s    = {CNT_W{1'b0}};
        gate_s  = {CNT_W{1'b0}};
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GATE;
                    win_d   = GATE_LOAD;
                end
            end
            S_GATE: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (win_q == 32'd0) begin
                    state_d = S_WAIT;
                    to_d    = TO_LOAD;
                end else begin
                    win_d = win_q - 32'd1;
                end
            end
            S_WAIT: begin
                // A cnt_done coincident with the last timeout cycle still wins.
                if (!en) begin
                    state_d = S_IDLE;
                end else if (cnt_done) begin
                    state_d = S_SEND;
                    load_s  = 1'b1;
                    hdr_s   = HDR_OK;
                    fx_s    = fx_cnt;
                    gate_s  = gate_cnt;
                end else if (to_q == 32'd0) begin
                    state_d = S_SEND;
                    load_s  = 1'b1;
                    hdr_s   = HDR_TO;
                end else begin
                    to_d = to_q - 32'd1;
                end
            end
            S_SEND: begin
                if (last_xfer_s) begin
                    state_d = S_HOLDOFF;
                    win_d   = HOLD_LOAD;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_HOLDOFF: begin
                if (win_q == 32'd0) begin
                    state_d = en ? S_CLEAR : S_IDLE;
                end else begin
                    win_d = win_q - 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        cnt_clr_d = (state_d == S_CLEAR);
        gate_en_d = (state_d == S_GATE);
        busy_d    = (state_d != S_IDLE);
    end

    // State, counters and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            win_q     <= {CNT_W{1'b0}};
            to_q      <= {CNT_W{1'b0}};
            cnt_clr_q <= 1'b0;
            gate_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            to_q      <= to_d;
            cnt_clr_q <= cnt_clr_d;
            gate_en_q <= gate_en_d;
            busy_q    <= busy_d;
        end
    end

    meas_frame_tx u_frame_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .hdr       (hdr_s),
        .fx        (fx_s),
        .gate      (gate_s),
        .tx        (tx),
        .last_xfer (last_xfer_s),
        .done      (done_s)
    );

    assign cnt_clr   = cnt_clr_q;
    assign gate_en   = gate_en_q;
    assign busy      = busy_q;
    assign meas_done = done_s;

endmodule

// File: tb/tb_freq_meas_sched.sv
// Scoreboard bench for freq_meas_sched: directed scenarios push expected
// frame bytes; a negedge monitor pops and compares every accepted byte.
module tb_freq_meas_sched;
    import freq_meas_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cnt_done;
    logic [31:0] fx_cnt;
    logic [31:0] gate_cnt;
    logic        cnt_clr;
    logic        gate_en;
    logic        busy;
    logic        meas_done;

    freq_meas_sched_if tx_if ();

    freq_meas_sched #(
        .GATE_CYCLES    (32'd8),
        .HOLDOFF_CYCLES (32'd4),
        .TIMEOUT_CYCLES (32'd16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cnt_clr   (cnt_clr),
        .gate_en   (gate_en),
        .cnt_done  (cnt_done),
        .fx_cnt    (fx_cnt),
        .gate_cnt  (gate_cnt),
        .tx        (tx_if),
        .busy      (busy),
        .meas_done (meas_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input logic f, input logic l);
        exp_t e;
        e.data  = d;
        e.first = f;
        e.last  = l;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [79:0] fr);
        for (int i = 0; i < 10; i++) push_byte(fr[79-8*i -: 8], i == 0, i == 9);
    endtask

    function automatic logic sig_sel(input int s);
        case (s)
            0:       return gate_en;
            1:       return meas_done;
            2:       return cnt_clr;
            3:       return tx_if.tx_valid;
            4:       return busy;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait for a DUT output to reach a level; n = cycles waited.
    task automatic wait_for(input int s, input logic lvl, input int budget, output int n);
        n = 0;
        while (sig_sel(s) !== lvl && n < budget) begin
            tick();
            n++;
        end
        if (sig_sel(s) !== lvl) begin
            n_total++;
            $display("FAIL wait_sig%0d: no level %0b within %0d cycles", s, lvl, budget);
        end
    endtask

    task automatic pulse_done(input logic [31:0] fx, input logic [31:0] gt);
        fx_cnt   = fx;
        gate_cnt = gt;
        cnt_done = 1'b1;
        tick();
        cnt_done = 1'b0;
    endtask

    // Monitor: compares accepted bytes, stall stability and meas_done timing.
    initial begin
        exp_t       e;
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       done_exp;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        done_exp   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                done_exp   = 1'b0;
            end else begin
                if (done_exp) check("meas_done_after_last", 32'(meas_done), 32'd1);
                else if (meas_done) check("meas_done_spurious", 32'(meas_done), 32'd0);
                done_exp = 1'b0;
                if (prev_stall) begin
                    check("valid_held", 32'(tx_if.tx_valid), 32'd1);
                    check("data_stable", 32'(tx_if.tx_data), 32'(prev_data));
                end
                if (tx_if.tx_valid && tx_if.tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_byte: got 0x%0h, required no transfer", tx_if.tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_byte", 32'(tx_if.tx_data), 32'(e.data));
                        if (e.first) first_cyc = cyc;
                        if (e.last) begin
                            last_cyc = cyc;
                            done_exp = 1'b1;
                        end
                    end
                end
                prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
                prev_data  = tx_if.tx_data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic seen;
        rst = 1'b1; en = 1'b0; cnt_done = 1'b0; fx_cnt = 32'd0; gate_cnt = 32'd0;
        tx_if.tx_ready = 1'b1;
        tick(); tick();
        check("rst_cnt_clr",   32'(cnt_clr), 32'd0);
        check("rst_gate_en",   32'(gate_en), 32'd0);
        check("rst_tx_valid",  32'(tx_if.tx_valid), 32'd0);
        check("rst_tx_data",   32'(tx_if.tx_data), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_meas_done", 32'(meas_done), 32'd0);
        rst = 1'b0;
        tick();

        // Normal measurement, back-to-back frame
        en = 1'b1;
        tick();
        check("clr_pulse", 32'(cnt_clr), 32'd1);
        tick();
        check("clr_one_cycle", 32'(cnt_clr), 32'd0);
        check("gate_open", 32'(gate_en), 32'd1);
        wait_for(0, 1'b0, 20, n);
        check("gate_len", 32'(n), 32'd8);
        tick(); tick(); tick();
        push_frame(80'h55_01020304_0000000A_14);
        pulse_done(32'h01020304, 32'h0000000A);
        check("hdr_latency", 32'(tx_if.tx_valid), 32'd1);
        check("hdr_byte", 32'(tx_if.tx_data), 32'h55);
        wait_for(1, 1'b1, 40, n);
        check("span_b2b", 32'(last_cyc - first_cyc + 1), 32'd10);
        en = 1'b0;
        tick(); tick(); tick();
        check("holdoff_busy", 32'(busy), 32'd1);
        tick();
        check("holdoff_idle", 32'(busy), 32'd0);
        check("holdoff_no_clr", 32'(cnt_clr), 32'd0);

        // Timeout
        en = 1'b1;
        wait_for(0, 1'b1, 10, n);
        wait_for(0, 1'b0, 20, n);
        push_frame(80'hAA_00000000_00000000_00);
        wait_for(3, 1'b1, 30, n);
        check("timeout_latency", 32'(n), 32'd16);
        wait_for(1, 1'b1, 40, n);
        en = 1'b0;
        wait_for(4, 1'b0, 20, n);

        // Backpressure: tx_ready alternates starting high on the header
        tx_if.tx_ready = 1'b0;
        en = 1'b1;
        wait_for(0, 1'b1, 10, n);
        wait_for(0, 1'b0, 20, n);
        tick(); tick();
        push_frame(80'h55_01020304_0000000A_14);
        pulse_done(32'h01020304, 32'h0000000A);
        for (int i = 0; i < 40 && !meas_done; i++) begin
            tx_if.tx_ready = ~tx_if.tx_ready;
            tick();
        end
        check("bp_meas_done", 32'(meas_done), 32'd1);
        check("span_bp", 32'(last_cyc - first_cyc + 1), 32'd19);
        tx_if.tx_ready = 1'b1;
        en = 1'b0;
        wait_for(4, 1'b0, 20, n);

        // Abort at gate cycle 4
        en = 1'b1;
        wait_for(0, 1'b1, 10, n);
        tick(); tick(); tick();
        en = 1'b0;
        tick();
        check("abort_gate_en", 32'(gate_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_if.tx_valid) seen = 1'b1;
        end
        check("abort_no_tx", 32'(seen), 32'd0);

        // en dropped during byte 5: frame completes, then IDLE
        en = 1'b1;
        wait_for(0, 1'b1, 10, n);
        wait_for(0, 1'b0, 20, n);
        tick();
        push_frame(80'h55_DEADBEEF_12345678_4C);
        pulse_done(32'hDEADBEEF, 32'h12345678);
        tick(); tick(); tick(); tick();
        check("byte5_value", 32'(tx_if.tx_data), 32'hEF);
        en = 1'b0;
        wait_for(1, 1'b1, 20, n);
        tick(); tick(); tick();
        check("late_abort_holdoff", 32'(busy), 32'd1);
        tick();
        check("late_abort_idle", 32'(busy), 32'd0);
        check("late_abort_no_clr", 32'(cnt_clr), 32'd0);

        // Continuous: all-ones counts, stray cnt_done in GATE, holdoff spacing
        en = 1'b1;
        wait_for(0, 1'b1, 10, n);
        pulse_done(32'h11111111, 32'h22222222);
        wait_for(0, 1'b0, 20, n);
        tick();
        push_frame(80'h55_FFFFFFFF_FFFFFFFF_F8);
        pulse_done(32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_for(1, 1'b1, 40, n);
        wait_for(2, 1'b1, 10, n);
        check("holdoff_to_clr", 32'(n), 32'd4);
        // cnt_done on the final timeout cycle
        wait_for(0, 1'b1, 10, n);
        wait_for(0, 1'b0, 20, n);
        for (int i = 0; i < 15; i++) tick();
        push_frame(80'h55_00000001_00000002_03);
        pulse_done(32'h00000001, 32'h00000002);
        check("coincident_valid", 32'(tx_if.tx_valid), 32'd1);
        check("coincident_hdr", 32'(tx_if.tx_data), 32'h55);
        wait_for(1, 1'b1, 40, n);
        en = 1'b0;
        wait_for(4, 1'b0, 20, n);

        // Reset during byte 3
        en = 1'b1;
        wait_for(0, 1'b1, 10, n);
        wait_for(0, 1'b0, 20, n);
        tick();
        push_byte(8'h55, 1'b1, 1'b0);
        push_byte(8'h01, 1'b0, 1'b0);
        pulse_done(32'h01020304, 32'h0000000A);
        tick(); tick();
        tx_if.tx_ready = 1'b0;
        rst = 1'b1;
        en = 1'b0;
        tick();
        check("mid_rst_tx_valid",  32'(tx_if.tx_valid), 32'd0);
        check("mid_rst_tx_data",   32'(tx_if.tx_data), 32'd0);
        check("mid_rst_busy",      32'(busy), 32'd0);
        check("mid_rst_gate_en",   32'(gate_en), 32'd0);
        check("mid_rst_meas_done", 32'(meas_done), 32'd0);
        rst = 1'b0;
        tx_if.tx_ready = 1'b1;
        tick();
        en = 1'b1;
        tick();
        check("fresh_clr", 32'(cnt_clr), 32'd1);
        en = 1'b0;
        tick(); tick();
        check("fresh_abort_idle", 32'(busy), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
